// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Launches the multi-cycle divider or multiplier for one
//             MULT/DIV operation, owns the architectural HI/LO registers,
//             and flags divide-by-zero and runaway operations.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_finished,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        timeout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 of the limit suffices.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               op_sel_q, op_sel_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               timeout_q, timeout_d;
  logic               w_flag;

  // Completion flag of whichever unit was launched.
  assign w_flag = op_sel_q ? div_finished : mult_done;

  // State register and all architectural/pulse flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_sel_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_sel_q  <= op_sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, HI/LO update and pulse generation.
  always_comb begin
    state_d   = state_q;
    op_sel_d  = op_sel_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // MTHI/MTLO land here; an accepted op's WB overwrites them later.
        if (hi_we) hi_d = hilo_wdata;
        if (lo_we) lo_d = hilo_wdata;
        if (op_start) begin
          if (op_sel && (op_b == 32'd0)) begin
            dbz_d = 1'b1;
          end else begin
            op_sel_d = op_sel;
            a_d      = op_a;
            b_d      = op_b;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_SETTLE;
      S_SETTLE: begin
        // The divider's finished flag may still be stale here; ignore it.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (w_flag) begin
          hi_d    = op_sel_q ? div_remainder : mult_hi;
          lo_d    = op_sel_q ? div_quotient  : mult_lo;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign div_start    = (state_q == S_LAUNCH) &&  op_sel_q;
  assign mult_start   = (state_q == S_LAUNCH) && !op_sel_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign mult_a       = a_q;
  assign mult_b       = b_q;
  assign done         = done_q;
  assign div_by_zero  = dbz_q;
  assign timeout      = timeout_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Scoreboard bench for muldiv_sequencer with divider and
//             multiplier behavioural stubs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int TIMEOUT_CYCLES = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_start, op_sel;
  logic [31:0] op_a, op_b;
  logic        hi_we, lo_we;
  logic [31:0] hilo_wdata;
  logic        div_start;
  logic [31:0] div_dividend, div_divisor;
  logic        div_finished;
  logic [31:0] div_quotient, div_remainder;
  logic        mult_start;
  logic [31:0] mult_a, mult_b;
  logic        mult_done;
  logic [31:0] mult_hi, mult_lo;
  logic        busy, done, div_by_zero, timeout;
  logic [31:0] hi, lo;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .op_start(op_start), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_finished(div_finished), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .timeout(timeout),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Expected pulse: kind = {timeout, div_by_zero, done}; cyc < 0 = untimed.
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Divider stub: finished stays stale through the first post-start cycle.
  int          div_lat = 0;
  int          dcnt = 0;
  int          n_div_starts = 0;
  logic [31:0] da, db;
  always @(posedge clock) begin
    if (reset) begin
      dcnt         <= 0;
      div_finished <= 1'b0;
    end else if (div_start) begin
      dcnt         <= div_lat + 1;
      n_div_starts <= n_div_starts + 1;
      da           <= div_dividend;
      db           <= div_divisor;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_finished  <= 1'b1;
        div_quotient  <= $signed(da) / $signed(db);
        div_remainder <= $signed(da) % $signed(db);
      end else begin
        div_finished <= 1'b0;
      end
    end
  end

  // Multiplier stub: one-cycle done pulse after mult_lat cycles, or never.
  int   mult_lat = 0;
  bit   mult_never = 1'b0;
  int   mcnt = 0;
  logic [63:0] mprod;
  always @(posedge clock) begin
    mult_done <= 1'b0;
    if (reset) begin
      mcnt <= 0;
    end else if (mult_start) begin
      mcnt <= mult_never ? 0 : mult_lat + 1;
      mprod = {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mult_done <= 1'b1;
        mult_hi   <= mprod[63:32];
        mult_lo   <= mprod[31:0];
      end
    end
  end

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && (done || div_by_zero || timeout)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, timeout, div_by_zero, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {29'd0, timeout, div_by_zero, done}, {29'd0, e.kind});
        chk("pulse_hi", hi, e.hi);
        chk("pulse_lo", lo, e.lo);
        chk("pulse_busy", {31'd0, busy}, 32'd0);
        if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // One-cycle op_start; lat_edges = clock edges from acceptance to the pulse.
  task automatic issue(input logic sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] kind, input logic [31:0] eh, input logic [31:0] el,
                       input int lat_edges);
    @(negedge clock);
    op_start = 1'b1; op_sel = sel; op_a = a; op_b = b;
    if (kind != 3'b000) sb.push_back('{kind, eh, el, (lat_edges >= 0) ? cyc + 1 + lat_edges : -1});
    @(negedge clock);
    op_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clock);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge clock);
    hi_we = whi; lo_we = wlo; hilo_wdata = d;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int starts_before;
    reset = 1'b1; op_start = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pulses", {29'd0, timeout, div_by_zero, done}, 32'd0);

    // DIV 7/2, slow divider.
    div_lat = 32;
    issue(1'b1, 32'd7, 32'd2, 3'b001, 32'd1, 32'd3, -1);
    chk("div72_busy", {31'd0, busy}, 32'd1);
    wait_idle("div72_idle", 60);

    // DIV -7/2.
    div_lat = 5;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    wait_idle("divm72_idle", 30);

    // DIV 1/5 with finished already high: result after SETTLE, exact latency.
    div_lat = 0;
    issue(1'b1, 32'd1, 32'd5, 3'b001, 32'd1, 32'd0, 4);
    wait_idle("div15_idle", 20);
    @(negedge clock);

    // Preload HI/LO, then DIV 9/0.
    write_hilo(1'b1, 1'b0, 32'h0000_AAAA);
    write_hilo(1'b0, 1'b1, 32'h0000_5555);
    chk("mthi", hi, 32'h0000_AAAA);
    chk("mtlo", lo, 32'h0000_5555);
    starts_before = n_div_starts;
    issue(1'b1, 32'd9, 32'd0, 3'b010, 32'h0000_AAAA, 32'h0000_5555, 0);
    chk("dbz_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    chk("dbz_no_div_start", n_div_starts, starts_before);

    // MULT 0x10000 * 0x10000; op_start and MTLO while busy are ignored.
    mult_lat = 10;
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 3'b001, 32'd1, 32'd0, -1);
    op_start = 1'b1; op_sel = 1'b1; op_b = 32'd0; lo_we = 1'b1; hilo_wdata = 32'h0000_DEAD;
    @(negedge clock);
    op_start = 1'b0; lo_we = 1'b0;
    chk("mult_lo_held", lo, 32'h0000_5555);
    chk("mult_busy", {31'd0, busy}, 32'd1);
    wait_idle("mult_idle", 30);

    // Runaway multiply: timeout, HI/LO unchanged, then a new op works.
    mult_never = 1'b1;
    issue(1'b0, 32'd4, 32'd4, 3'b100, 32'd1, 32'd0, -1);
    wait_idle("timeout_idle", TIMEOUT_CYCLES + 20);
    mult_never = 1'b0;
    mult_lat = 2;
    issue(1'b0, 32'd3, 32'd5, 3'b001, 32'd0, 32'd15, -1);
    wait_idle("mult35_idle", 20);

    // Reset during WAIT of a DIV aborts it without a pulse.
    div_lat = 32;
    issue(1'b1, 32'd100, 32'd7, 3'b000, 32'd0, 32'd0, -1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    div_lat = 3;
    issue(1'b1, 32'd100, 32'd7, 3'b001, 32'd2, 32'd14, -1);
    wait_idle("div1007_idle", 20);

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
